// File: rtl/latency_profiler.sv
// ============================================================================
// Module   : latency_profiler
// Purpose  : Multi-channel start-to-done latency profiler. Each channel runs
//            an IDLE/RUN measurement FSM with a saturating latency counter
//            and keeps last/min/max/sum/count statistics, read back through
//            a channel-select mux.
// Ports    : clk           - system clock, rising edge
//            reset         - asynchronous active-low reset
//            start[c]      - begin a measurement on channel c
//            done[c]       - complete the running measurement on channel c
//            clear         - synchronous clear of stats and sticky flags
//            rd_sel        - readback channel select
//            running[c]    - channel c is measuring
//            result_valid  - 1-cycle pulse per completed sample
//            rd_last/rd_min/rd_max/rd_sum/rd_count - stats of channel rd_sel
//            sat_flag[c]   - sticky: latency counter hit its ceiling
//            overrun_flag  - sticky: start seen while already running
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module latency_profiler #(
    parameter int CHANNELS  = 4,
    parameter int WIDTH     = 16,
    parameter int ACC_WIDTH = 32,
    parameter int CNT_WIDTH = 16,
    localparam int SEL_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [CHANNELS-1:0]  start,
    input  logic [CHANNELS-1:0]  done,
    input  logic                 clear,
    input  logic [SEL_W-1:0]     rd_sel,
    output logic [CHANNELS-1:0]  running,
    output logic [CHANNELS-1:0]  result_valid,
    output logic [WIDTH-1:0]     rd_last,
    output logic [WIDTH-1:0]     rd_min,
    output logic [WIDTH-1:0]     rd_max,
    output logic [ACC_WIDTH-1:0] rd_sum,
    output logic [CNT_WIDTH-1:0] rd_count,
    output logic [CHANNELS-1:0]  sat_flag,
    output logic [CHANNELS-1:0]  overrun_flag
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0]     c_lat_max = '1;
    localparam logic [ACC_WIDTH-1:0] c_sum_max = '1;
    localparam logic [CNT_WIDTH-1:0] c_cnt_max = '1;

    // Per-channel stats gathered into arrays for the readback mux
    logic [WIDTH-1:0]     w_last  [CHANNELS];
    logic [WIDTH-1:0]     w_min   [CHANNELS];
    logic [WIDTH-1:0]     w_max   [CHANNELS];
    logic [ACC_WIDTH-1:0] w_sum   [CHANNELS];
    logic [CNT_WIDTH-1:0] w_count [CHANNELS];

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        state_t               r_state;
        state_t               w_state_nxt;
        logic [WIDTH-1:0]     r_cur;
        logic [WIDTH-1:0]     w_cur_nxt;
        logic                 w_sample;
        logic                 w_ovr_evt;
        logic                 w_sat_evt;
        logic                 r_rv;
        logic                 r_sat;
        logic                 r_ovr;

        logic [WIDTH-1:0]     r_last;
        logic [WIDTH-1:0]     r_min;
        logic [WIDTH-1:0]     r_max;
        logic [ACC_WIDTH-1:0] r_sum;
        logic [CNT_WIDTH-1:0] r_count;

        // Stats after an optional clear, before folding in a new sample, so
        // that clear plus a coinciding sample yields exactly that sample.
        logic [WIDTH-1:0]     w_min_base;
        logic [WIDTH-1:0]     w_max_base;
        logic [ACC_WIDTH-1:0] w_sum_base;
        logic [CNT_WIDTH-1:0] w_cnt_base;
        logic [ACC_WIDTH:0]   w_sum_add;
        logic [CNT_WIDTH:0]   w_cnt_add;

        // ---------------- measurement FSM: next state ----------------
        always_comb begin
            w_state_nxt = r_state;
            w_cur_nxt   = r_cur;
            w_sample    = 1'b0;
            w_ovr_evt   = 1'b0;
            w_sat_evt   = 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // done while idle is meaningless and ignored
                    if (start[g]) begin
                        w_state_nxt = ST_RUN;
                        w_cur_nxt   = WIDTH'(1);
                    end
                end
                ST_RUN: begin
                    w_ovr_evt = start[g];
                    if (done[g]) begin
                        w_sample    = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else if (r_cur != c_lat_max) begin
                        w_cur_nxt = r_cur + 1'b1;
                        w_sat_evt = (r_cur == c_lat_max - 1'b1);
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end

        // ---------------- measurement FSM: state register ----------------
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_state <= ST_IDLE;
                r_cur   <= '0;
                r_rv    <= 1'b0;
                r_sat   <= 1'b0;
                r_ovr   <= 1'b0;
            end else begin
                r_state <= w_state_nxt;
                r_cur   <= w_cur_nxt;
                r_rv    <= w_sample;
                // a new event on the clearing edge still registers
                r_sat   <= w_sat_evt | (r_sat & ~clear);
                r_ovr   <= w_ovr_evt | (r_ovr & ~clear);
            end
        end

        // ---------------- statistics ----------------
        always_comb begin
            w_min_base = clear ? c_lat_max : r_min;
            w_max_base = clear ? '0        : r_max;
            w_sum_base = clear ? '0        : r_sum;
            w_cnt_base = clear ? '0        : r_count;
            w_sum_add  = {1'b0, w_sum_base} + {{(ACC_WIDTH - WIDTH + 1){1'b0}}, r_cur};
            w_cnt_add  = {1'b0, w_cnt_base} + 1'b1;
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_last  <= '0;
                r_min   <= c_lat_max;
                r_max   <= '0;
                r_sum   <= '0;
                r_count <= '0;
            end else if (w_sample) begin
                r_last  <= r_cur;
                r_min   <= (r_cur < w_min_base) ? r_cur : w_min_base;
                r_max   <= (r_cur > w_max_base) ? r_cur : w_max_base;
                r_sum   <= w_sum_add[ACC_WIDTH] ? c_sum_max : w_sum_add[ACC_WIDTH-1:0];
                r_count <= w_cnt_add[CNT_WIDTH] ? c_cnt_max : w_cnt_add[CNT_WIDTH-1:0];
            end else if (clear) begin
                r_last  <= '0;
                r_min   <= c_lat_max;
                r_max   <= '0;
                r_sum   <= '0;
                r_count <= '0;
            end
        end

        assign running[g]      = (r_state == ST_RUN);
        assign result_valid[g] = r_rv;
        assign sat_flag[g]     = r_sat;
        assign overrun_flag[g] = r_ovr;
        assign w_last[g]       = r_last;
        assign w_min[g]        = r_min;
        assign w_max[g]        = r_max;
        assign w_sum[g]        = r_sum;
        assign w_count[g]      = r_count;
    end

    // ---------------- readback mux ----------------
    // Select values past the last channel read as zero.
    logic w_sel_ok;
    assign w_sel_ok = (32'(rd_sel) < CHANNELS);

    always_comb begin
        rd_last  = '0;
        rd_min   = '0;
        rd_max   = '0;
        rd_sum   = '0;
        rd_count = '0;
        if (w_sel_ok) begin
            rd_last  = w_last[rd_sel];
            rd_min   = w_min[rd_sel];
            rd_max   = w_max[rd_sel];
            rd_sum   = w_sum[rd_sel];
            rd_count = w_count[rd_sel];
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_latency_profiler.sv
// ============================================================================
// Module   : tb_latency_profiler
// Purpose  : Self-checking bench for latency_profiler. A default-sized
//            instance is tracked by a timestamp-based reference model; a
//            narrow instance (WIDTH=4, ACC_WIDTH=8, CNT_WIDTH=4, 3 channels)
//            exercises saturation and out-of-range readback.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_latency_profiler;

    localparam int     CH   = 4;
    localparam longint LMAX = 65535;
    localparam longint SMAX = 64'hFFFF_FFFF;
    localparam longint CMAX = 65535;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  start, done;
    logic        clear;
    logic [1:0]  rd_sel;
    logic [3:0]  running, result_valid, sat_flag, overrun_flag;
    logic [15:0] rd_last, rd_min, rd_max, rd_count;
    logic [31:0] rd_sum;

    logic [2:0]  s4_start, s4_done, s4_running, s4_rv, s4_sat, s4_ovr;
    logic        s4_clear;
    logic [1:0]  s4_sel;
    logic [3:0]  s4_last, s4_min, s4_max, s4_count;
    logic [7:0]  s4_sum;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    latency_profiler dut (
        .clk(clk), .reset(reset), .start(start), .done(done), .clear(clear),
        .rd_sel(rd_sel), .running(running), .result_valid(result_valid),
        .rd_last(rd_last), .rd_min(rd_min), .rd_max(rd_max), .rd_sum(rd_sum),
        .rd_count(rd_count), .sat_flag(sat_flag), .overrun_flag(overrun_flag)
    );

    latency_profiler #(.CHANNELS(3), .WIDTH(4), .ACC_WIDTH(8), .CNT_WIDTH(4)) dut4 (
        .clk(clk), .reset(reset), .start(s4_start), .done(s4_done), .clear(s4_clear),
        .rd_sel(s4_sel), .running(s4_running), .result_valid(s4_rv),
        .rd_last(s4_last), .rd_min(s4_min), .rd_max(s4_max), .rd_sum(s4_sum),
        .rd_count(s4_count), .sat_flag(s4_sat), .overrun_flag(s4_ovr)
    );

    // ---------------- reference model (main instance) ----------------
    // Tracks measurements by edge timestamps: latency = done edge - start edge.
    int     cyc;
    bit     m_run [CH];
    int     m_t0  [CH];
    longint m_last[CH], m_min[CH], m_max[CH], m_sum[CH], m_cnt[CH];
    bit     m_rv  [CH], m_sat[CH], m_ovr[CH];

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            m_run[c] = 0; m_t0[c] = 0; m_rv[c] = 0; m_sat[c] = 0; m_ovr[c] = 0;
            m_last[c] = 0; m_min[c] = LMAX; m_max[c] = 0; m_sum[c] = 0; m_cnt[c] = 0;
        end
    endtask

    task automatic model_edge();
        longint lat;
        cyc++;
        if (clear) begin
            for (int c = 0; c < CH; c++) begin
                m_last[c] = 0; m_min[c] = LMAX; m_max[c] = 0; m_sum[c] = 0; m_cnt[c] = 0;
                m_sat[c] = 0; m_ovr[c] = 0;
            end
        end
        for (int c = 0; c < CH; c++) begin
            m_rv[c] = 0;
            if (!m_run[c]) begin
                if (start[c]) begin m_run[c] = 1; m_t0[c] = cyc; end
            end else begin
                if (start[c]) m_ovr[c] = 1;
                if (done[c]) begin
                    lat = longint'(cyc - m_t0[c]);
                    if (lat > LMAX) lat = LMAX;
                    m_run[c] = 0; m_rv[c] = 1; m_last[c] = lat;
                    if (lat < m_min[c]) m_min[c] = lat;
                    if (lat > m_max[c]) m_max[c] = lat;
                    m_sum[c] = (m_sum[c] + lat > SMAX) ? SMAX : m_sum[c] + lat;
                    m_cnt[c] = (m_cnt[c] + 1 > CMAX) ? CMAX : m_cnt[c] + 1;
                end else if (longint'(cyc - m_t0[c]) + 1 == LMAX) begin
                    m_sat[c] = 1;
                end
            end
        end
    endtask

    // One clock: the model consumes the inputs sampled on this edge, then
    // outputs are observed 1 ns later.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic run_sample(input int ch, input int lat);
        start[ch] = 1'b1; step(); start[ch] = 1'b0;
        repeat (lat - 1) step();
        done[ch] = 1'b1; step(); done[ch] = 1'b0;
    endtask

    task automatic run4_sample(input int lat);
        s4_start[0] = 1'b1; step(); s4_start[0] = 1'b0;
        repeat (lat - 1) step();
        s4_done[0] = 1'b1; step(); s4_done[0] = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b0; start = '0; done = '0; clear = 1'b0; rd_sel = '0;
        s4_start = '0; s4_done = '0; s4_clear = 1'b0; s4_sel = '0;
        repeat (3) @(posedge clk);
        model_reset(); cyc = 0;
        @(negedge clk); reset = 1'b1;
        #1;
        checks++; if (running !== 4'h0) begin errors++; $display("FAIL reset_running: got %h exp 0", running); end
        checks++; if (result_valid !== 4'h0) begin errors++; $display("FAIL reset_rv: got %h exp 0", result_valid); end
        checks++; if (sat_flag !== 4'h0 || overrun_flag !== 4'h0) begin errors++; $display("FAIL reset_flags: got sat=%h ovr=%h exp 0", sat_flag, overrun_flag); end
        for (int c = 0; c < CH; c++) begin
            rd_sel = 2'(c); #1;
            checks++;
            if (rd_last !== 16'h0 || rd_min !== 16'hFFFF || rd_max !== 16'h0 || rd_sum !== 32'h0 || rd_count !== 16'h0) begin
                errors++;
                $display("FAIL reset_stats ch%0d: got last=%0h min=%0h max=%0h sum=%0h cnt=%0h exp 0/ffff/0/0/0",
                         c, rd_last, rd_min, rd_max, rd_sum, rd_count);
            end
        end
        s4_sel = 2'd0; #1;
        checks++; if (s4_min !== 4'hF) begin errors++; $display("FAIL reset_w4_min: got %h exp f", s4_min); end
        s4_sel = 2'd3; #1;
        checks++; if (s4_min !== 4'h0 || s4_last !== 4'h0 || s4_sum !== 8'h0) begin errors++; $display("FAIL sel_out_of_range: got min=%h last=%h sum=%h exp 0", s4_min, s4_last, s4_sum); end
        s4_sel = 2'd0;
    endtask

    task automatic test_single();
        start[0] = 1'b1; step(); start[0] = 1'b0;
        checks++; if (running[0] !== 1'b1) begin errors++; $display("FAIL single_running: got %b exp 1", running[0]); end
        repeat (4) step();
        checks++; if (result_valid[0] !== 1'b0) begin errors++; $display("FAIL single_rv_early: got %b exp 0", result_valid[0]); end
        done[0] = 1'b1; step(); done[0] = 1'b0;
        checks++; if (result_valid !== 4'b0001) begin errors++; $display("FAIL single_rv: got %b exp 0001", result_valid); end
        checks++; if (running[0] !== 1'b0) begin errors++; $display("FAIL single_idle: got %b exp 0", running[0]); end
        rd_sel = 2'd0; #1;
        checks++;
        if (rd_last !== 16'd5 || rd_min !== 16'd5 || rd_max !== 16'd5 || rd_sum !== 32'd5 || rd_count !== 16'd1) begin
            errors++;
            $display("FAIL single_stats: got last=%0d min=%0d max=%0d sum=%0d cnt=%0d exp 5/5/5/5/1",
                     rd_last, rd_min, rd_max, rd_sum, rd_count);
        end
        step();
        checks++; if (result_valid[0] !== 1'b0) begin errors++; $display("FAIL single_rv_pulse: got %b exp 0", result_valid[0]); end
    endtask

    task automatic test_multi();
        run_sample(1, 3);
        run_sample(1, 9);
        run_sample(1, 4);
        rd_sel = 2'd1; #1;
        checks++;
        if (rd_last !== 16'd4 || rd_min !== 16'd3 || rd_max !== 16'd9 || rd_sum !== 32'd16 || rd_count !== 16'd3) begin
            errors++;
            $display("FAIL multi_ch1: got last=%0d min=%0d max=%0d sum=%0d cnt=%0d exp 4/3/9/16/3",
                     rd_last, rd_min, rd_max, rd_sum, rd_count);
        end
        rd_sel = 2'd0; #1;
        checks++;
        if (rd_last !== 16'd5 || rd_count !== 16'd1 || rd_sum !== 32'd5) begin
            errors++;
            $display("FAIL multi_ch0_kept: got last=%0d sum=%0d cnt=%0d exp 5/5/1", rd_last, rd_sum, rd_count);
        end
    endtask

    task automatic test_overrun();
        start[2] = 1'b1; step(); start[2] = 1'b0;
        step(); step();
        start[2] = 1'b1; step(); start[2] = 1'b0;
        step();
        done[2] = 1'b1; step(); done[2] = 1'b0;
        checks++; if (overrun_flag !== 4'b0100) begin errors++; $display("FAIL overrun_flag: got %b exp 0100", overrun_flag); end
        rd_sel = 2'd2; #1;
        checks++; if (rd_last !== 16'd5) begin errors++; $display("FAIL overrun_latency: got %0d exp 5", rd_last); end
        // start and done together while idle: enter RUN, no sample
        start[2] = 1'b1; done[2] = 1'b1; step(); start[2] = 1'b0; done[2] = 1'b0;
        checks++; if (running[2] !== 1'b1 || result_valid[2] !== 1'b0) begin errors++; $display("FAIL idle_start_done: got run=%b rv=%b exp 1/0", running[2], result_valid[2]); end
        done[2] = 1'b1; step(); done[2] = 1'b0;
        #1;
        checks++;
        if (rd_last !== 16'd1 || rd_min !== 16'd1 || rd_max !== 16'd5 || rd_count !== 16'd2 || result_valid[2] !== 1'b1) begin
            errors++;
            $display("FAIL min_latency: got last=%0d min=%0d max=%0d cnt=%0d rv=%b exp 1/1/5/2/1",
                     rd_last, rd_min, rd_max, rd_count, result_valid[2]);
        end
    endtask

    task automatic test_clear();
        start[3] = 1'b1; step(); start[3] = 1'b0;
        start[0] = 1'b1; step(); start[0] = 1'b0;
        repeat (6) step();
        done[0] = 1'b1; clear = 1'b1; step(); done[0] = 1'b0; clear = 1'b0;
        rd_sel = 2'd0; #1;
        checks++;
        if (rd_last !== 16'd7 || rd_min !== 16'd7 || rd_max !== 16'd7 || rd_sum !== 32'd7 || rd_count !== 16'd1) begin
            errors++;
            $display("FAIL clear_with_sample: got last=%0d min=%0d max=%0d sum=%0d cnt=%0d exp 7/7/7/7/1",
                     rd_last, rd_min, rd_max, rd_sum, rd_count);
        end
        checks++; if (overrun_flag !== 4'h0) begin errors++; $display("FAIL clear_flags: got %b exp 0000", overrun_flag); end
        rd_sel = 2'd1; #1;
        checks++; if (rd_min !== 16'hFFFF || rd_count !== 16'd0) begin errors++; $display("FAIL clear_ch1: got min=%0h cnt=%0d exp ffff/0", rd_min, rd_count); end
        checks++; if (running[3] !== 1'b1) begin errors++; $display("FAIL clear_keeps_run: got %b exp 1", running[3]); end
        repeat (2) step();
        done[3] = 1'b1; step(); done[3] = 1'b0;
        rd_sel = 2'd3; #1;
        checks++; if (rd_last !== 16'd11 || rd_count !== 16'd1) begin errors++; $display("FAIL clear_ch3_sample: got last=%0d cnt=%0d exp 11/1", rd_last, rd_count); end
    endtask

    task automatic test_saturation();
        s4_start[0] = 1'b1; step(); s4_start[0] = 1'b0;
        repeat (13) step();
        checks++; if (s4_sat[0] !== 1'b0) begin errors++; $display("FAIL sat_early: got %b exp 0", s4_sat[0]); end
        step();
        checks++; if (s4_sat[0] !== 1'b1) begin errors++; $display("FAIL sat_set: got %b exp 1", s4_sat[0]); end
        repeat (6) step();
        s4_done[0] = 1'b1; step(); s4_done[0] = 1'b0;
        s4_sel = 2'd0; #1;
        checks++;
        if (s4_rv !== 3'b001 || s4_last !== 4'd15 || s4_sum !== 8'd15 || s4_count !== 4'd1) begin
            errors++;
            $display("FAIL sat_sample: got rv=%b last=%0d sum=%0d cnt=%0d exp 001/15/15/1", s4_rv, s4_last, s4_sum, s4_count);
        end
        for (int i = 0; i < 19; i++) run4_sample(15);
        #1;
        checks++;
        if (s4_sum !== 8'd255 || s4_count !== 4'd15 || s4_min !== 4'd15 || s4_max !== 4'd15) begin
            errors++;
            $display("FAIL acc_cnt_saturate: got sum=%0d cnt=%0d min=%0d max=%0d exp 255/15/15/15", s4_sum, s4_count, s4_min, s4_max);
        end
    endtask

    task automatic test_random();
        logic [3:0] e_run, e_rv, e_sat, e_ovr;
        for (int n = 0; n < 300; n++) begin
            for (int c = 0; c < CH; c++) begin
                start[c] = ($urandom_range(0, 5) == 0);
                done[c]  = ($urandom_range(0, 3) == 0);
            end
            clear = ($urandom_range(0, 63) == 0);
            step();
            start = '0; done = '0; clear = 1'b0;
            for (int c = 0; c < CH; c++) begin
                e_run[c] = m_run[c]; e_rv[c] = m_rv[c]; e_sat[c] = m_sat[c]; e_ovr[c] = m_ovr[c];
            end
            checks++;
            if (running !== e_run || result_valid !== e_rv || sat_flag !== e_sat || overrun_flag !== e_ovr) begin
                errors++;
                $display("FAIL rand_status cyc%0d: got run=%b rv=%b sat=%b ovr=%b exp %b/%b/%b/%b",
                         cyc, running, result_valid, sat_flag, overrun_flag, e_run, e_rv, e_sat, e_ovr);
            end
            for (int c = 0; c < CH; c++) begin
                rd_sel = 2'(c); #1;
                checks++;
                if (rd_last !== 16'(m_last[c]) || rd_min !== 16'(m_min[c]) || rd_max !== 16'(m_max[c]) ||
                    rd_sum !== 32'(m_sum[c]) || rd_count !== 16'(m_cnt[c])) begin
                    errors++;
                    $display("FAIL rand_stats cyc%0d ch%0d: got %0d/%0d/%0d/%0d/%0d exp %0d/%0d/%0d/%0d/%0d",
                             cyc, c, rd_last, rd_min, rd_max, rd_sum, rd_count,
                             m_last[c], m_min[c], m_max[c], m_sum[c], m_cnt[c]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        start[1] = 1'b1; step(); start[1] = 1'b0;
        repeat (3) step();
        #2 reset = 1'b0;
        #1;
        model_reset();
        checks++; if (running !== 4'h0) begin errors++; $display("FAIL midreset_running: got %b exp 0000", running); end
        rd_sel = 2'd1; #1;
        checks++; if (rd_min !== 16'hFFFF || rd_count !== 16'd0) begin errors++; $display("FAIL midreset_stats: got min=%0h cnt=%0d exp ffff/0", rd_min, rd_count); end
        @(negedge clk); reset = 1'b1;
        done[1] = 1'b1; step(); done[1] = 1'b0;
        checks++; if (result_valid !== 4'h0 || running !== 4'h0) begin errors++; $display("FAIL midreset_no_rv: got rv=%b run=%b exp 0000/0000", result_valid, running); end
        step();
        checks++; if (result_valid !== 4'h0) begin errors++; $display("FAIL midreset_no_rv2: got %b exp 0000", result_valid); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_multi();
        test_overrun();
        test_clear();
        test_saturation();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/latency_profiler.md
Name: latency_profiler

Overview:
- Multi-channel successor to the single-channel inference latency counter.
- Measures start-to-done latency on CHANNELS independent channels.
- Keeps per-channel statistics: last, min, max, saturating sum and sample count. Stats are read back through a channel-select mux.
- Sits beside the inference engines and feeds the debug/telemetry register bank.

Parameters:
- CHANNELS, 4, number of independent measurement channels (1..16).
- WIDTH, 16, latency counter width. Latencies saturate at 2^WIDTH-1.
- ACC_WIDTH, 32, width of the per-channel latency sum (must be >= WIDTH).
- CNT_WIDTH, 16, width of the per-channel sample counter.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  CHANNELS  per-channel start pulse, sampled each edge.
- done  in  CHANNELS  per-channel completion, sampled each edge.
- clear  in  1  synchronous statistics clear, all channels.
- rd_sel  in  $clog2(CHANNELS) (min 1)  readback channel select.
- running  out  CHANNELS  channel measurement in progress.
- result_valid  out  CHANNELS  1-cycle pulse: sample completed on the previous edge.
- rd_last  out  WIDTH  last completed latency of channel rd_sel.
- rd_min  out  WIDTH  minimum latency of rd_sel.
- rd_max  out  WIDTH  maximum latency of rd_sel.
- rd_sum  out  ACC_WIDTH  saturating latency sum of rd_sel.
- rd_count  out  CNT_WIDTH  completed samples on rd_sel (saturating).
- sat_flag  out  CHANNELS  sticky: a latency saturated at 2^WIDTH-1.
- overrun_flag  out  CHANNELS  sticky: start arrived while already running.

Behaviour:
- Reset (reset=0, async):
  - running, result_valid, sat_flag, overrun_flag = 0.
  - Per channel: cur=0, last=0, min=all-ones, max=0, sum=0, count=0.
- Per-channel FSM, states IDLE and RUN:
  - IDLE & start: go to RUN, cur<=1. done in the same cycle is ignored.
  - IDLE & !start: stay. done is ignored.
  - RUN & !done: cur<=cur+1, saturating at 2^WIDTH-1. Entering saturation sets sat_flag.
  - RUN & done: sample L=cur. Go to IDLE, result_valid<=1 next cycle, update stats.
  - RUN & start: overrun_flag<=1. start is otherwise ignored; the measurement continues. If done is also high, the sample still completes.
- Latency definition: start sampled at edge E0, done sampled at edge E0+N gives L=N. Minimum legal L=1 (done high on the edge after start).
- Stats update on sample L:
  - last<=L.
  - min<=min(min,L); max<=max(max,L).
  - sum<=sum+L, saturating at 2^ACC_WIDTH-1.
  - count<=count+1, saturating at 2^CNT_WIDTH-1.
- clear (synchronous, 1 cycle):
  - Resets last/min/max/sum/count, sat_flag and overrun_flag on all channels.
  - Does not abort in-flight measurements; running and cur are untouched.
  - clear and a completing sample in the same cycle: the stats equal that single sample (last=min=max=sum=L, count=1).
- Readback: rd_* is a combinational mux of registered stats indexed by rd_sel.
  - Out-of-range rd_sel reads all zeros.
  - A stat updated at edge E is visible on rd_* after E.
- Channels are fully independent; simultaneous events on different channels never interact.
- Reset asserted mid-measurement: the channel returns to IDLE, no result_valid, all stats reset.

Test Plan:
- Ch0: start at edge 10, done at edge 15 -> result_valid[0] pulse after edge 15; rd_sel=0 gives last=5, min=5, max=5, sum=5, count=1.
- Ch1: three samples with L=3, 9, 4 -> last=4, min=3, max=9, sum=16, count=3; ch0 stats unaffected.
- WIDTH=4: hold done low for 20 cycles after start -> cur sticks at 15, sat_flag set, completed L=15.
- start re-pulsed on ch2 mid-run -> overrun_flag[2]=1, latency still measured from the first start. Same-cycle start+done while IDLE -> RUN entered, no sample.
- clear coincident with ch0 done at L=7 -> min=max=last=sum=7, count=1, flags cleared. clear during a ch3 run -> ch3 still completes correctly.
- reset asserted 3 cycles into a run -> running=0 immediately, min=all-ones, count=0, no result_valid after release.
